// File: rtl/pipe_stage_chain_pkg.sv
// Shared pipeline-register definitions: default NOP bubble
// and the core's packed inter-stage bundles.
package pipe_stage_chain_pkg;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
  } id_ex_t;

endpackage

// File: rtl/pipe_stage_chain_if.sv
// Upstream valid/ready/data handshake into the stage chain.
// master: producer drives valid/data; slave: chain drives ready.
interface pipe_stage_chain_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/pipe_stage_chain_slot.sv
// One pipeline register (payload + valid).
// Priority: rst > flush > hold > bubble > load.
module pipe_stage_chain_slot
  import pipe_stage_chain_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] BUBBLE    = WIDTH'(NOP_INSN),
  parameter logic             RST_VALID = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             hold,
  input  logic             bubble,
  input  logic             d_valid,
  input  logic [WIDTH-1:0] d_data,
  output logic             q_valid,
  output logic [WIDTH-1:0] q_data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q_data  <= BUBBLE;
      q_valid <= RST_VALID;
    end else if (flush) begin
      q_data  <= BUBBLE;
      q_valid <= 1'b0;
    end else if (hold) begin
      q_data  <= q_data;
      q_valid <= q_valid;
    end else if (bubble) begin
      q_data  <= BUBBLE;
      q_valid <= 1'b0;
    end else begin
      q_data  <= d_data;
      q_valid <= d_valid;
    end
  end

endmodule

// File: rtl/pipe_stage_chain.sv
// Chain of NUM_STAGES registers with per-stage stall/flush,
// upstream hold propagation and a saturating stall counter.
module pipe_stage_chain
  import pipe_stage_chain_pkg::*;
#(
  parameter int          NUM_STAGES = 4,
  parameter int          WIDTH      = 32,
  parameter logic [31:0] BUBBLE     = NOP_INSN,
  parameter logic        RST_VALID  = 1'b0,
  parameter int          CNT_W      = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_STAGES-1:0]       stall,
  input  logic [NUM_STAGES-1:0]       flush,
  pipe_stage_chain_if.slave           up,
  output logic [NUM_STAGES*WIDTH-1:0] stage_data,
  output logic [NUM_STAGES-1:0]       stage_valid,
  output logic [NUM_STAGES-1:0]       hold_o,
  output logic                        out_valid,
  output logic [WIDTH-1:0]            out_data,
  output logic [CNT_W-1:0]            stall_cycles
);

  localparam logic [WIDTH-1:0] BUB     = WIDTH'(BUBBLE);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_STAGES-1:0] hold;
  logic [NUM_STAGES-1:0] valid_q;
  logic [WIDTH-1:0]      data_q [NUM_STAGES];

  // A stage holds if it or anything downstream stalls.
  always_comb begin
    hold = stall;
    for (int i = NUM_STAGES - 2; i >= 0; i--) begin
      hold[i] = stall[i] | hold[i+1];
    end
  end

  assign hold_o      = hold;
  assign up.in_ready = ~hold[0];

  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
    logic             d_valid;
    logic [WIDTH-1:0] d_data;
    logic             bub;

    if (i == 0) begin : g_head
      assign d_valid = up.in_valid;
      assign d_data  = up.in_data;
      assign bub     = 1'b0;
    end else begin : g_body
      assign d_valid = valid_q[i-1];
      assign d_data  = data_q[i-1];
      assign bub     = hold[i-1];
    end

    pipe_stage_chain_slot #(
      .WIDTH     (WIDTH),
      .BUBBLE    (BUB),
      .RST_VALID (RST_VALID)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush[i]),
      .hold    (hold[i]),
      .bubble  (bub),
      .d_valid (d_valid),
      .d_data  (d_data),
      .q_valid (valid_q[i]),
      .q_data  (data_q[i])
    );

    assign stage_data[i*WIDTH +: WIDTH] = data_q[i];
  end

  assign stage_valid = valid_q;
  assign out_valid   = valid_q[NUM_STAGES-1];
  assign out_data    = data_q[NUM_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (hold[0] && stall_cycles != CNT_MAX) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule
